cv32e40p_obi_arbiter: RTL and testbench

Two-requester OBI arbiter. It shares the single core-side OBI master port (the output of the OBI interface block) between port 0 (instruction fetch) and port 1 (load/store). Arbitration is round-robin, and the arbiter locks onto a requester until its transaction is granted. An in-order ID FIFO routes each rvalid/rdata/err response back to the requester that issued it.

---
 rtl/cv32e40p_obi_arbiter.sv | 154 +++++++++++++++
 tb/tb_cv32e40p_obi_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_arbiter.sv
// Purpose: round-robin arbiter sharing one OBI master port between instruction fetch (m0) and load/store (m1).
// Latency: zero-cycle request/grant and response paths, with combinational muxing and an in-order ID FIFO for routing.
// Backpressure: locks onto the selected requester until it is granted, and stalls new requests while MAX_OUTSTANDING are in flight.
module cv32e40p_obi_arbiter #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  output logic        m0_gnt_o,
  input  logic [31:0] m0_addr_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [5:0]  m0_atop_i,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  output logic        m1_gnt_o,
  input  logic [31:0] m1_addr_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [5:0]  m1_atop_i,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        obi_req_o,
  input  logic        obi_gnt_i,
  output logic [31:0] obi_addr_o,
  output logic        obi_we_o,
  output logic [3:0]  obi_be_o,
  output logic [31:0] obi_wdata_o,
  output logic [5:0]  obi_atop_o,
  input  logic [31:0] obi_rdata_i,
  input  logic        obi_rvalid_i,
  input  logic        obi_err_i,

  output logic        busy_o
);

  localparam int               PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t           state_q;
  logic             sel_q;
  logic             rr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic             id_mem [MAX_OUTSTANDING];

  logic room;
  logic sel;
  logic req;
  logic hs;
  logic pop;
  logic head;

  // Full is only reachable through a grant, so a locked requester always has room.
  assign room = (cnt_q < CNT_MAX);

  // Winner selection: the locked port wins, otherwise a lone requester, otherwise the round-robin port.
  always_comb begin
    sel = 1'b0;
    if (state_q == LOCKED) begin
      sel = sel_q;
    end else if (m0_req_i && m1_req_i) begin
      sel = rr_q;
    end else begin
      sel = m1_req_i;
    end
  end

  assign req  = rst_n & ((state_q == LOCKED) | ((m0_req_i | m1_req_i) & room));
  assign hs   = req & obi_gnt_i;
  assign pop  = rst_n & obi_rvalid_i & (cnt_q != '0);
  assign head = id_mem[rd_ptr_q];

  assign obi_req_o   = req;
  assign obi_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign obi_we_o    = sel ? m1_we_i    : m0_we_i;
  assign obi_be_o    = sel ? m1_be_i    : m0_be_i;
  assign obi_wdata_o = sel ? m1_wdata_i : m0_wdata_i;
  assign obi_atop_o  = sel ? m1_atop_i  : m0_atop_i;

  assign m0_gnt_o    = hs & ~sel;
  assign m1_gnt_o    = hs & sel;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = obi_rdata_i;
  assign m1_rdata_o  = obi_rdata_i;
  assign m0_err_o    = obi_err_i;
  assign m1_err_o    = obi_err_i;
  assign busy_o      = rst_n & (cnt_q != '0);

  // Lock FSM, round-robin pointer, outstanding counter and ID FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      sel_q    <= 1'b0;
      rr_q     <= 1'b1;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          if (req && !obi_gnt_i) begin
            state_q <= LOCKED;
            sel_q   <= sel;
          end
        end
        LOCKED: begin
          if (obi_gnt_i) begin
            state_q <= UNLOCKED;
          end
        end
        default: state_q <= UNLOCKED;
      endcase

      if (hs) begin
        rr_q     <= ~sel;
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end

      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end

      if (hs && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!hs && pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  // ID storage: records which port owns each granted transaction, in issue order.
  always_ff @(posedge clk) begin
    if (hs) begin
      id_mem[wr_ptr_q] <= sel;
    end
  end

endmodule

// File: tb/tb_cv32e40p_obi_arbiter.sv
// Testbench for the two-port OBI arbiter: directed scenarios with literal expectations,
// then randomized traffic, checked on every cycle against a queue-based model of the arbitration rules.
module tb_cv32e40p_obi_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m1_req, m0_gnt, m1_gnt;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [5:0]  m0_atop, m1_atop;
  logic        m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        obi_req_o, obi_gnt, obi_we_o, obi_rvalid, obi_err, busy;
  logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata;
  logic [3:0]  obi_be_o;
  logic [5:0]  obi_atop_o;

  int nvec = 0;
  int nerr = 0;
  bit pend0, pend1;

  cv32e40p_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_we_i(m0_we),
    .m0_be_i(m0_be), .m0_wdata_i(m0_wdata), .m0_atop_i(m0_atop),
    .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_we_i(m1_we),
    .m1_be_i(m1_be), .m1_wdata_i(m1_wdata), .m1_atop_i(m1_atop),
    .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .obi_req_o(obi_req_o), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr_o), .obi_we_o(obi_we_o),
    .obi_be_o(obi_be_o), .obi_wdata_o(obi_wdata_o), .obi_atop_o(obi_atop_o),
    .obi_rdata_i(obi_rdata), .obi_rvalid_i(obi_rvalid), .obi_err_i(obi_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner queue of granted-but-unanswered transactions, a held selection
  // for a presented-but-ungranted request, and the port that wins the next tie.
  bit m_q[$];
  bit m_lk = 1'b0;
  bit m_lp = 1'b0;
  bit m_rr = 1'b1;

  always @(negedge clk) begin : model
    bit ereq, esel, ehs, epop, ehead;
    ereq = 1'b0;
    esel = 1'b0;
    if (rst_n) begin
      if (m_lk) begin
        ereq = 1'b1;
        esel = m_lp;
      end else begin
        esel = (m0_req && m1_req) ? m_rr : m1_req;
        ereq = (m0_req || m1_req) && (m_q.size() < MAXO);
      end
    end
    ehs   = ereq && obi_gnt;
    epop  = rst_n && obi_rvalid && (m_q.size() > 0);
    ehead = (m_q.size() > 0) ? m_q[0] : 1'b0;

    check("mdl_obi_req", obi_req_o, ereq);
    check("mdl_m0_gnt", m0_gnt, ehs && !esel);
    check("mdl_m1_gnt", m1_gnt, ehs && esel);
    check("mdl_m0_rvalid", m0_rvalid, epop && !ehead);
    check("mdl_m1_rvalid", m1_rvalid, epop && ehead);
    check("mdl_busy", busy, rst_n && (m_q.size() != 0));
    check("mdl_m0_rdata", m0_rdata, obi_rdata);
    check("mdl_m1_rdata", m1_rdata, obi_rdata);
    check("mdl_errs", {m1_err, m0_err}, {obi_err, obi_err});
    if (ereq) begin
      check("mdl_addr", obi_addr_o, esel ? m1_addr : m0_addr);
      check("mdl_wdata", obi_wdata_o, esel ? m1_wdata : m0_wdata);
      check("mdl_we_be_atop", {obi_we_o, obi_be_o, obi_atop_o},
            esel ? {m1_we, m1_be, m1_atop} : {m0_we, m0_be, m0_atop});
    end

    if (!rst_n) begin
      m_q.delete();
      m_lk = 1'b0;
      m_rr = 1'b1;
    end else begin
      if (epop) void'(m_q.pop_front());
      if (ehs) begin
        m_q.push_back(esel);
        m_rr = !esel;
        m_lk = 1'b0;
      end else if (ereq) begin
        m_lk = 1'b1;
        m_lp = esel;
      end
    end
  end

  task automatic idle();
    m0_req = 1'b0; m1_req = 1'b0; obi_gnt = 1'b0;
    obi_rvalid = 1'b0; obi_err = 1'b0; obi_rdata = 32'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    cyc(); idle(); rst_n = 1'b0;
    cyc(); idle(); rst_n = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    m0_addr = 32'h0; m0_we = 1'b0; m0_be = 4'hF; m0_wdata = 32'h0; m0_atop = 6'h0;
    m1_addr = 32'h0; m1_we = 1'b1; m1_be = 4'h3; m1_wdata = 32'h11; m1_atop = 6'h0;
    pend0 = 1'b0; pend1 = 1'b0;

    // Reset held with live requests, grants and responses: everything stays quiet.
    cyc(); m0_req = 1'b1; obi_gnt = 1'b1; obi_rvalid = 1'b1; settle();
    check("rst_obi_req", obi_req_o, 0);
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("rst_busy", busy, 0);

    // Single requester, same-cycle grant, response two cycles later.
    cyc(); rst_n = 1'b1; idle(); m0_req = 1'b1; m0_addr = 32'h100; obi_gnt = 1'b1; settle();
    check("single_m0_gnt", m0_gnt, 1);
    check("single_m1_gnt", m1_gnt, 0);
    check("single_addr", obi_addr_o, 32'h100);
    cyc(); idle(); settle();
    check("single_busy", busy, 1);
    cyc(); obi_rvalid = 1'b1; obi_rdata = 32'hDEADBEEF; settle();
    check("single_m0_rvalid", m0_rvalid, 1);
    check("single_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("single_m1_rvalid", m1_rvalid, 0);
    cyc(); idle(); settle();
    check("single_idle_busy", busy, 0);

    // Contention: grants alternate m1,m0,m1,m0; responses follow the same order.
    do_reset();
    m0_addr = 32'h1000; m1_addr = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      cyc(); idle();
      m0_req = (i < 4); m1_req = (i < 4); obi_gnt = 1'b1; obi_rvalid = (i > 0);
      settle();
      if (i < 4) begin
        check("rr_m1_gnt", m1_gnt, (i % 2 == 0));
        check("rr_m0_gnt", m0_gnt, (i % 2 == 1));
        check("rr_addr", obi_addr_o, (i % 2 == 0) ? 32'h2000 : 32'h1000);
      end
      if (i > 0) begin
        check("rr_m1_rvalid", m1_rvalid, (i % 2 == 1));
        check("rr_m0_rvalid", m0_rvalid, (i % 2 == 0));
        check("rr_busy", busy, 1);
      end
    end
    cyc(); idle(); settle();
    check("rr_drained", busy, 0);

    // Lock: m0 waits without a grant while m1 arrives; m0 keeps the port until granted.
    do_reset();
    cyc(); m0_req = 1'b1; m0_addr = 32'h200; m1_addr = 32'h300; settle();
    check("lock_req", obi_req_o, 1);
    check("lock_m0_gnt", m0_gnt, 0);
    check("lock_addr0", obi_addr_o, 32'h200);
    for (int i = 0; i < 2; i++) begin
      cyc(); m1_req = 1'b1; settle();
      check("lock_addr_hold", obi_addr_o, 32'h200);
      check("lock_m1_blocked", m1_gnt, 0);
    end
    cyc(); obi_gnt = 1'b1; settle();
    check("lock_m0_granted", m0_gnt, 1);
    check("lock_m1_not", m1_gnt, 0);
    cyc(); m0_req = 1'b0; settle();
    check("lock_m1_next", m1_gnt, 1);
    check("lock_addr1", obi_addr_o, 32'h300);
    cyc(); m1_req = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b1; settle();
    check("lock_rsp0", m0_rvalid, 1);
    cyc(); settle();
    check("lock_rsp1", m1_rvalid, 1);
    cyc(); idle();

    // Outstanding limit, error response and spurious response.
    do_reset();
    cyc(); m0_req = 1'b1; m1_req = 1'b1; obi_gnt = 1'b1; settle();
    check("full_g1", m1_gnt, 1);
    cyc(); settle();
    check("full_g0", m0_gnt, 1);
    cyc(); m0_req = 1'b0; obi_rvalid = 1'b1; settle();
    check("full_no_req", obi_req_o, 0);
    check("full_no_gnt", m1_gnt, 0);
    check("full_pop_m1", m1_rvalid, 1);
    cyc(); obi_rvalid = 1'b0; settle();
    check("full_resume_req", obi_req_o, 1);
    check("full_resume_gnt", m1_gnt, 1);
    cyc(); m1_req = 1'b0; obi_gnt = 1'b0; obi_rvalid = 1'b1; settle();
    check("full_rsp_m0", m0_rvalid, 1);
    check("full_rsp_not_m1", m1_rvalid, 0);
    cyc(); obi_err = 1'b1; settle();
    check("err_m1_rvalid", m1_rvalid, 1);
    check("err_m1_err", m1_err, 1);
    cyc(); obi_err = 1'b0; settle();
    check("spur_rvalid", {m1_rvalid, m0_rvalid}, 0);
    check("spur_busy", busy, 0);
    cyc(); idle();

    // Reset with two outstanding, then a stray response, then a normal grant.
    do_reset();
    cyc(); m0_req = 1'b1; m1_req = 1'b1; obi_gnt = 1'b1; settle();
    cyc(); settle();
    check("rst2_busy_before", busy, 1);
    cyc(); rst_n = 1'b0; settle();
    check("rst2_busy", busy, 0);
    check("rst2_gnts", {m1_gnt, m0_gnt}, 0);
    check("rst2_req", obi_req_o, 0);
    cyc(); rst_n = 1'b1; idle(); obi_rvalid = 1'b1; settle();
    check("rst2_stray", {m1_rvalid, m0_rvalid}, 0);
    check("rst2_stray_busy", busy, 0);
    cyc(); idle(); m0_req = 1'b1; m0_addr = 32'h400; obi_gnt = 1'b1; settle();
    check("rst2_m0_gnt", m0_gnt, 1);
    check("rst2_addr", obi_addr_o, 32'h400);
    cyc(); idle();

    // Randomized traffic: requesters hold req and attributes until granted.
    for (int n = 0; n < 4000; n++) begin
      cyc();
      rst_n = ($urandom_range(199) != 0);
      if (!pend0 && $urandom_range(2) == 0) begin
        pend0 = 1'b1;
        m0_addr = $urandom; m0_wdata = $urandom; m0_we = 1'($urandom_range(1));
        m0_be = 4'($urandom); m0_atop = 6'($urandom);
      end
      if (!pend1 && $urandom_range(2) == 0) begin
        pend1 = 1'b1;
        m1_addr = $urandom; m1_wdata = $urandom; m1_we = 1'($urandom_range(1));
        m1_be = 4'($urandom); m1_atop = 6'($urandom);
      end
      m0_req = pend0;
      m1_req = pend1;
      obi_gnt = ($urandom_range(3) != 0);
      obi_rvalid = ($urandom_range(2) == 0);
      obi_rdata = $urandom;
      obi_err = ($urandom_range(7) == 0);
      settle();
      if (m0_gnt) pend0 = 1'b0;
      if (m1_gnt) pend1 = 1'b0;
    end

    cyc(); idle(); rst_n = 1'b1;
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
